// File: rtl/mem_req_queue.sv
// In-order request FIFO feeding one memory port, plus a tag-indexed pending table
// that routes tagged load data back to the requester ID that issued the load.
module mem_req_queue #(
  parameter int QDEPTH = 4,
  parameter int ID_W   = 3,
  parameter int XLEN   = 32
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic [1:0]      req_command,
  input  logic [XLEN-1:0] req_addr,
  input  logic [63:0]     req_data,
  input  logic [1:0]      req_size,
  input  logic [ID_W-1:0] req_id,
  output logic [1:0]      proc2mem_command,
  output logic [XLEN-1:0] proc2mem_addr,
  output logic [63:0]     proc2mem_data,
  output logic [1:0]      proc2mem_size,
  input  logic [3:0]      mem2proc_response,
  input  logic [63:0]     mem2proc_data,
  input  logic [3:0]      mem2proc_tag,
  output logic            rsp_valid,
  output logic [ID_W-1:0] rsp_id,
  output logic [63:0]     rsp_data,
  output logic            st_ack_valid,
  output logic [ID_W-1:0] st_ack_id,
  output logic            err_tag,
  output logic [4:0]      outstanding
);

  // Bus encodings: NONE=0, LOAD=1, STORE=2; size WORD=2.
  localparam logic [1:0] BUS_NONE = 2'd0;
  localparam logic [1:0] BUS_LOAD = 2'd1;
  localparam logic [1:0] SZ_WORD  = 2'd2;

  localparam int PW = $clog2(QDEPTH);
  localparam int CW = PW + 1;
  localparam logic [PW-1:0] PTR_ONE = PW'(1);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);
  localparam logic [CW-1:0] DEPTH_C = CW'(QDEPTH);

  typedef struct packed {
    logic [1:0]      cmd;
    logic [XLEN-1:0] addr;
    logic [63:0]     data;
    logic [1:0]      size;
    logic [ID_W-1:0] id;
  } entry_t;

  entry_t          fifo_q [QDEPTH];
  entry_t          fifo_d [QDEPTH];
  logic [PW-1:0]   head_q, head_d, tail_q, tail_d;
  logic [CW-1:0]   count_q, count_d;
  logic            pend_valid_q [1:15];
  logic            pend_valid_d [1:15];
  logic [ID_W-1:0] pend_id_q [1:15];
  logic [ID_W-1:0] pend_id_d [1:15];
  logic            rsp_valid_q, rsp_valid_d;
  logic [ID_W-1:0] rsp_id_q, rsp_id_d;
  logic [63:0]     rsp_data_q, rsp_data_d;
  logic            st_ack_valid_q, st_ack_valid_d;
  logic [ID_W-1:0] st_ack_id_q, st_ack_id_d;
  logic            err_q, err_d;
  logic [4:0]      outstanding_q, outstanding_d;

  entry_t          head_s;
  logic            empty_s, push_s, pop_s, ld_acc_s, ret_hit_s;
  logic [ID_W-1:0] ret_id_s;

  // FIFO control and combinational drive of the memory port from the head entry.
  always_comb begin
    head_s    = fifo_q[head_q];
    empty_s   = (count_q == {CW{1'b0}});
    req_ready = (count_q < DEPTH_C);
    push_s    = req_valid && req_ready && (req_command != BUS_NONE);
    pop_s     = !empty_s && (mem2proc_response != 4'd0);
    ld_acc_s  = pop_s && (head_s.cmd == BUS_LOAD);

    if (empty_s) begin
      proc2mem_command = BUS_NONE;
      proc2mem_addr    = {XLEN{1'b0}};
      proc2mem_data    = 64'd0;
      proc2mem_size    = SZ_WORD;
    end else begin
      proc2mem_command = head_s.cmd;
      proc2mem_addr    = head_s.addr;
      proc2mem_data    = head_s.data;
      proc2mem_size    = head_s.size;
    end

    fifo_d = fifo_q;
    head_d = head_q;
    tail_d = tail_q;
    if (push_s) begin
      fifo_d[tail_q] = '{cmd: req_command, addr: req_addr, data: req_data,
                         size: req_size, id: req_id};
      tail_d = tail_q + PTR_ONE;
    end else begin
      tail_d = tail_q;
    end
    if (pop_s) begin
      head_d = head_q + PTR_ONE;
    end else begin
      head_d = head_q;
    end

    case ({push_s, pop_s})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase
  end

  // Pending-table update, return routing, store acks and error detection.
  always_comb begin
    pend_valid_d = pend_valid_q;
    pend_id_d    = pend_id_q;
    ret_hit_s    = 1'b0;
    ret_id_s     = {ID_W{1'b0}};
    err_d        = err_q;

    if (mem2proc_tag != 4'd0) begin
      if (pend_valid_q[mem2proc_tag]) begin
        ret_hit_s                  = 1'b1;
        ret_id_s                   = pend_id_q[mem2proc_tag];
        pend_valid_d[mem2proc_tag] = 1'b0;
      end else begin
        err_d = 1'b1;
      end
    end else begin
      ret_hit_s = 1'b0;
    end

    // A return freeing the same tag this cycle makes the reuse legal.
    if (ld_acc_s) begin
      if (pend_valid_q[mem2proc_response] &&
          !(ret_hit_s && (mem2proc_tag == mem2proc_response))) begin
        err_d = 1'b1;
      end else begin
        err_d = err_d;
      end
      pend_valid_d[mem2proc_response] = 1'b1;
      pend_id_d[mem2proc_response]    = head_s.id;
    end else begin
      pend_valid_d = pend_valid_d;
    end

    if (empty_s && (mem2proc_response != 4'd0)) begin
      err_d = 1'b1;
    end else begin
      err_d = err_d;
    end

    rsp_valid_d    = ret_hit_s;
    rsp_id_d       = ret_id_s;
    rsp_data_d     = ret_hit_s ? mem2proc_data : 64'd0;
    st_ack_valid_d = pop_s && (head_s.cmd != BUS_LOAD);
    st_ack_id_d    = st_ack_valid_d ? head_s.id : {ID_W{1'b0}};

    outstanding_d = 5'd0;
    for (int i = 1; i <= 15; i++) begin
      outstanding_d = outstanding_d + {4'd0, pend_valid_d[i]};
    end
  end

  // State registers with asynchronous active-low clear.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < QDEPTH; i++) begin
        fifo_q[i] <= '0;
      end
      for (int t = 1; t <= 15; t++) begin
        pend_valid_q[t] <= 1'b0;
        pend_id_q[t]    <= {ID_W{1'b0}};
      end
      head_q         <= {PW{1'b0}};
      tail_q         <= {PW{1'b0}};
      count_q        <= {CW{1'b0}};
      rsp_valid_q    <= 1'b0;
      rsp_id_q       <= {ID_W{1'b0}};
      rsp_data_q     <= 64'd0;
      st_ack_valid_q <= 1'b0;
      st_ack_id_q    <= {ID_W{1'b0}};
      err_q          <= 1'b0;
      outstanding_q  <= 5'd0;
    end else begin
      fifo_q         <= fifo_d;
      pend_valid_q   <= pend_valid_d;
      pend_id_q      <= pend_id_d;
      head_q         <= head_d;
      tail_q         <= tail_d;
      count_q        <= count_d;
      rsp_valid_q    <= rsp_valid_d;
      rsp_id_q       <= rsp_id_d;
      rsp_data_q     <= rsp_data_d;
      st_ack_valid_q <= st_ack_valid_d;
      st_ack_id_q    <= st_ack_id_d;
      err_q          <= err_d;
      outstanding_q  <= outstanding_d;
    end
  end

  assign rsp_valid    = rsp_valid_q;
  assign rsp_id       = rsp_id_q;
  assign rsp_data     = rsp_data_q;
  assign st_ack_valid = st_ack_valid_q;
  assign st_ack_id    = st_ack_id_q;
  assign err_tag      = err_q;
  assign outstanding  = outstanding_q;

endmodule

// File: doc/mem_req_queue.md
# mem_req_queue

Request buffer and tag tracker that sits directly upstream of one `mem` port, e.g. port 0, and drives its `proc2mem_*` inputs. It accepts load/store requests from the load-store unit into an in-order FIFO and presents the head to memory. It records the tag memory returns for each accepted load. When the tagged data comes back, it routes the data to the original requester ID.

## Interface
- `QDEPTH`, 4: FIFO entries (power of 2, ≥2).
- `ID_W`, 3: requester ID width.
- `clock`  in  1  system clock; all state updates on posedge.
- `reset`  in  1  asynchronous, active-low; clears all state immediately.
- `req_valid`  in  1  request offered this cycle.
- `req_ready`  out  1  queue can accept; equals `count < QDEPTH`.
- `req_command`  in  2  `BUS_LOAD` or `BUS_STORE`; `BUS_NONE` with `req_valid` is dropped.
- `req_addr`  in  `XLEN`  byte address.
- `req_data`  in  64  store data.
- `req_size`  in  `MEM_SIZE`  BYTE/HALF/WORD/DOUBLE.
- `req_id`  in  `ID_W`  requester tag returned with completion.
- `proc2mem_command`  out  2  head command when non-empty; otherwise `BUS_NONE`.
- `proc2mem_addr`  out  `XLEN`  head address; 0 when empty.
- `proc2mem_data`  out  64  head data; 0 when empty.
- `proc2mem_size`  out  `MEM_SIZE`  head size; `WORD` when empty.
- `mem2proc_response`  in  4  nonzero means the head was accepted this cycle; the value is its tag.
- `mem2proc_data`  in  64  load data qualified by `mem2proc_tag`.
- `mem2proc_tag`  in  4  nonzero means data for that tag is valid this cycle.
- `rsp_valid`  out  1  registered load completion.
- `rsp_id`  out  `ID_W`  ID of the completed load.
- `rsp_data`  out  64  load data.
- `st_ack_valid`  out  1  registered store-accepted pulse.
- `st_ack_id`  out  `ID_W`  ID of the accepted store.
- `err_tag`  out  1  sticky protocol-error flag.
- `outstanding`  out  5  count of valid pending-table entries.

## Operation
- FIFO:
  - Circular buffer with `head`, `tail` and `count` (width `$clog2(QDEPTH)+1`).
  - Push when `req_valid && req_ready && req_command != BUS_NONE`.
  - Pop when `count != 0 && mem2proc_response != 0`.
  - Push and pop in the same cycle leave `count` unchanged.
  - Pointers wrap modulo `QDEPTH`.
- The head drives the memory port combinationally; there is no extra register stage.
- `mem2proc_response != 0` while the FIFO is empty is ignored and sets `err_tag`.
- Pending table: 15 entries indexed by tag 1..15, each holding `{valid, id}`. Tag 0 is never used.
  - Load accepted with response T: `pend[T] <= {1, head.id}`. If `pend[T].valid` is already set and is not being cleared this cycle, set `err_tag`; the new entry still overwrites.
  - Store accepted: nothing enters the table. Next cycle `st_ack_valid=1`, `st_ack_id=head.id`.
- Return handling:
  - When `mem2proc_tag=T≠0` and `pend[T].valid`: next cycle `rsp_valid=1`, `rsp_id=pend[T].id`, `rsp_data=mem2proc_data`; clear `pend[T]`.
  - When `mem2proc_tag=T≠0` and the entry is not valid: no response; set `err_tag`.
- Same-cycle return of T and acceptance of a new load with tag T:
  - The return reads the old entry and responds with the old id.
  - The table ends with the new entry valid.
  - No error.
- `outstanding` = popcount of pending valid bits, registered.
- Reset (asserted at any time, including mid-transaction):
  - FIFO empties, pending table is invalidated, `err_tag` clears.
  - All registered outputs go to 0; `req_ready=1`; `proc2mem_command=BUS_NONE`.
  - Returns arriving after reset for tags issued before it hit empty entries and set `err_tag`.

## Timing
- Request to memory: an entry pushed at edge N appears on `proc2mem_*` in cycle N+1, when the FIFO was empty.
- Acceptance pops at the same edge that samples `mem2proc_response`.
- Store acknowledge: `st_ack_valid` is high for exactly one cycle, the cycle after acceptance.
- Load completion: `rsp_valid` is high for exactly one cycle, the cycle after the `mem2proc_tag` match.
- Completions may be out of order with respect to issue; ordering follows memory tag returns.
- `req_ready` is combinational from `count`; a full queue does not accept even if a pop occurs that cycle.
- Throughput: one push and one pop per cycle.

## Test plan
- Reset with `reset=0`, then release → `req_ready=1`, `proc2mem_command=BUS_NONE`, `rsp_valid=0`, `outstanding=0`, `err_tag=0`.
- Store then load:
  - Push store addr 0x40 data 0x55 id 2, then load addr 0x40 id 5.
  - Memory responds 3 then 4 on consecutive cycles → `st_ack_valid` with id 2.
  - `mem2proc_tag=4` with data 0x55 → next cycle `rsp_valid=1`, `rsp_id=5`, `rsp_data=0x55`.
- Full queue:
  - Push 4 loads with `mem2proc_response=0` → `req_ready=0` and the fifth request is not accepted.
  - Respond once → `req_ready=1` next cycle and the head advances to the second address.
- Out-of-order returns:
  - Loads with ids 1, 2, 3 are accepted with tags 7, 8, 9.
  - Returns arrive in the order 9, 7, 8 → `rsp_id` sequence 3, 1, 2; `outstanding` goes 3→2→1→0.
- Tag reuse:
  - Load id 4 has tag 5 pending.
  - Return of tag 5 coincides with acceptance of load id 6 assigned tag 5 → `rsp_id=4`, `pend[5].id=6`, `err_tag=0`.
- Errors and reset mid-operation:
  - Return of tag 12 with no pending entry → no `rsp_valid`, `err_tag=1`.
  - Assert reset with 2 queued and 2 pending → all cleared immediately; a later return of an old tag sets `err_tag`.
